// File: rtl/lenet_pkg.sv
// lenet_pkg : shared constants, state encoding and data types for the LeNet host interface.
`default_nettype none

package lenet_pkg;

    localparam int BITWIDTH    = 9;
    localparam int IMG_DIM     = 28;
    localparam int NUM_PIX     = IMG_DIM * IMG_DIM;
    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } host_state_t;

    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef logic signed [BITWIDTH-1:0] score_t;

endpackage

`default_nettype wire

// File: rtl/lenet_host_if_argmax_scan.sv
// argmax_scan : captures a score vector on start and walks it one entry per cycle (rev 1.0).
`default_nettype none

module argmax_scan
    import lenet_pkg::*;
#(
    parameter int SCORE_W = BITWIDTH
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     start,
    input  logic [NUM_CLASSES-1:0][SCORE_W-1:0]      vec,
    output logic                                     done,
    output logic [3:0]                               class_idx,
    output logic signed [SCORE_W-1:0]                score
);

    logic signed [SCORE_W-1:0] captured [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best;
    logic [3:0]                best_idx;
    logic [3:0]                scan_idx;
    logic                      active;
    logic                      take;

    // Strictly greater: on a tie the earlier (lower) index is kept.
    assign take      = captured[scan_idx] > best;
    assign done      = active && (scan_idx == 4'(NUM_CLASSES - 1));
    assign class_idx = take ? scan_idx : best_idx;
    assign score     = take ? captured[scan_idx] : best;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                captured[i] <= '0;
            end
            best     <= '0;
            best_idx <= '0;
            scan_idx <= '0;
            active   <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                captured[i] <= vec[i];
            end
            best     <= vec[0];
            best_idx <= 4'd0;
            scan_idx <= 4'd1;
            active   <= 1'b1;
        end else if (active) begin
            if (take) begin
                best     <= captured[scan_idx];
                best_idx <= scan_idx;
            end
            if (done) begin
                active <= 1'b0;
            end else begin
                scan_idx <= scan_idx + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lenet_host_if.sv
// lenet_host_if : serial pixel loader feeding Lenet_accelerator's image port and an
// argmax-based result handshake on its output vector (rev 1.0).
`default_nettype none

module lenet_host_if #(
    parameter int BITWIDTH    = 9,
    parameter int ACC_LATENCY = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   pix_valid,
    output logic                                   pix_ready,
    input  logic signed [BITWIDTH-1:0]             pix_data,
    output logic signed [27:0][27:0][BITWIDTH-1:0] frame,
    input  logic signed [9:0][BITWIDTH-1:0]        scores,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [3:0]                             res_class,
    output logic signed [BITWIDTH-1:0]             res_score,
    output logic                                   busy
);

    import lenet_pkg::*;

    localparam int                  WCNT_W    = $clog2(ACC_LATENCY + 2);
    localparam logic [WCNT_W-1:0]   WAIT_LAST = WCNT_W'(ACC_LATENCY);
    localparam logic [4:0]          LAST_RC   = 5'(IMG_DIM - 1);

    host_state_t             state;
    logic [4:0]              row;
    logic [4:0]              col;
    logic [WCNT_W-1:0]       wait_cnt;
    logic                    scan_start;
    logic                    scan_done;
    logic [3:0]              scan_class;
    logic signed [BITWIDTH-1:0] scan_score;

    assign pix_ready = (state == ST_LOAD);
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_LOAD);

    // The accelerator output is trusted on the (ACC_LATENCY+1)-th edge spent in WAIT.
    assign scan_start = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);

    argmax_scan #(
        .SCORE_W   (BITWIDTH)
    ) u_argmax (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (scan_start),
        .vec       (scores),
        .done      (scan_done),
        .class_idx (scan_class),
        .score     (scan_score)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_LOAD;
            row       <= '0;
            col       <= '0;
            wait_cnt  <= '0;
            frame     <= '0;
            res_class <= '0;
            res_score <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (pix_valid) begin
                        frame[row][col] <= pix_data;
                        if (col == LAST_RC) begin
                            col <= '0;
                            if (row == LAST_RC) begin
                                row      <= '0;
                                wait_cnt <= '0;
                                state    <= ST_WAIT;
                            end else begin
                                row <= row + 5'd1;
                            end
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_SCAN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_done) begin
                        res_class <= scan_class;
                        res_score <= scan_score;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lenet_host_if.sv
// tb_lenet_host_if : table-driven and randomized self-checking bench for lenet_host_if.
`default_nettype none

module tb_lenet_host_if;

    import lenet_pkg::*;

    localparam int W   = 9;
    localparam int LAT = 4;
    localparam int NTBL = 12;

    typedef struct packed {
        logic [9:0][W-1:0]   sc;
        logic [3:0]          cls;
        logic signed [W-1:0] scr;
    } vec_t;

    logic                        clk = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        pix_valid = 1'b0;
    logic                        pix_ready;
    logic signed [W-1:0]         pix_data = '0;
    logic signed [27:0][27:0][W-1:0] frame;
    logic signed [9:0][W-1:0]    scores = '0;
    logic                        res_valid;
    logic                        res_ready = 1'b0;
    logic [3:0]                  res_class;
    logic signed [W-1:0]         res_score;
    logic                        busy;

    always #5 clk = ~clk;

    lenet_host_if #(
        .BITWIDTH    (W),
        .ACC_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .frame     (frame),
        .scores    (scores),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_score (res_score),
        .busy      (busy)
    );

    int   tests = 0;
    int   fails = 0;
    int   exp_frame [IMG_DIM][IMG_DIM];
    int   model_k;
    vec_t tbl [NTBL];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int fr(input int r, input int c);
        logic signed [W-1:0] v;
        v = frame[r][c];
        return int'(v);
    endfunction

    function automatic int sc_at(input logic [9:0][W-1:0] sc, input int i);
        logic signed [W-1:0] v;
        v = sc[i];
        return int'(v);
    endfunction

    // Reference: the highest value, reported at the first position it occurs.
    task automatic ref_argmax(input logic [9:0][W-1:0] sc, output int cls, output int scr);
        int mx;
        mx = sc_at(sc, 0);
        for (int i = 1; i < NUM_CLASSES; i++) if (sc_at(sc, i) > mx) mx = sc_at(sc, i);
        cls = -1;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) if (sc_at(sc, i) == mx) cls = i;
        scr = mx;
    endtask

    function automatic logic [9:0][W-1:0] mk(input int base, input int i1, input int v1,
                                              input int i2, input int v2);
        logic [9:0][W-1:0] r;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            r[i] = W'(base);
            if (i == i1) r[i] = W'(v1);
            if (i == i2) r[i] = W'(v2);
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                exp_frame[r][c] = 0;
        model_k = 0;
    endtask

    task automatic check_frame(input string name);
        int bad;
        bad = 0;
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                if (fr(r, c) != exp_frame[r][c]) begin
                    if (bad == 0)
                        $display("FAIL %s: frame[%0d][%0d] got %0d, expected %0d",
                                 name, r, c, fr(r, c), exp_frame[r][c]);
                    bad++;
                end
        check({name, "_bad_entries"}, bad, 0);
    endtask

    task automatic check_reset_state(input string tag);
        int nz;
        check({tag, "_pix_ready"}, int'(pix_ready), 1);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_res_class"}, int'(res_class), 0);
        check({tag, "_res_score"}, int'(res_score), 0);
        check({tag, "_busy"}, int'(busy), 0);
        nz = 0;
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                if (fr(r, c) != 0) nz++;
        check({tag, "_frame_nonzero"}, nz, 0);
    endtask

    task automatic send_pixel(input int d, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick;
        end
        pix_valid = 1'b1;
        pix_data  = W'(d);
        n = 0;
        while (!pix_ready && n < 50) begin
            tick;
            n++;
        end
        if (!pix_ready) check("pix_ready_timeout", 0, 1);
        tick;
        exp_frame[model_k / IMG_DIM][model_k % IMG_DIM] = d;
        model_k++;
    endtask

    task automatic run_image(input logic [9:0][W-1:0] sc, input int exp_cls, input int exp_scr,
                             input bit gaps, input bit hold_valid, input int hold_cycles,
                             input bit ramp);
        int cycles;
        int unstable;
        int d;
        for (int i = 0; i < NUM_CLASSES; i++) scores[i] = sc[i];
        model_k = 0;
        for (int k = 0; k < NUM_PIX; k++) begin
            d = ramp ? (k % 512) - 256 : int'($urandom_range(0, 511)) - 256;
            if (k == NUM_PIX - 1) check("busy_before_last_pixel", int'(busy), 0);
            send_pixel(d, gaps);
        end
        check("busy_after_last_pixel", int'(busy), 1);
        check("pix_ready_after_last_pixel", int'(pix_ready), 0);
        check_frame("frame_after_load");
        if (ramp) begin
            int bad;
            bad = 0;
            for (int r = 0; r < IMG_DIM; r++)
                for (int c = 0; c < IMG_DIM; c++)
                    if (fr(r, c) != ((28 * r + c) % 512) - 256) bad++;
            check("ramp_formula_bad_entries", bad, 0);
        end
        pix_valid = hold_valid;
        cycles = 0;
        while (!res_valid && cycles < 100) begin
            if (hold_valid) pix_data = W'($urandom_range(0, 511));
            tick;
            cycles++;
        end
        check("res_valid_latency", cycles, LAT + 10);
        check("res_class", int'(res_class), exp_cls);
        check("res_score", int'(res_score), exp_scr);
        check_frame("frame_frozen_after_load");
        if (hold_cycles > 0) begin
            unstable = 0;
            for (int i = 0; i < hold_cycles; i++) begin
                if (hold_valid) pix_data = W'($urandom_range(0, 511));
                tick;
                if (!res_valid || int'(res_class) != exp_cls || int'(res_score) != exp_scr)
                    unstable++;
            end
            check("result_stable_under_backpressure", unstable, 0);
            check_frame("frame_frozen_in_done");
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        pix_valid = 1'b0;
        check("res_valid_after_handshake", int'(res_valid), 0);
        check("pix_ready_after_handshake", int'(pix_ready), 1);
        check("busy_after_handshake", int'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cls;
        int scr;

        tbl[0].sc = mk(-5, 7, 100, -1, 0);     tbl[0].cls = 4'd7; tbl[0].scr = 9'sd100;
        tbl[1].sc = mk(0, 2, 50, 8, 50);       tbl[1].cls = 4'd2; tbl[1].scr = 9'sd50;
        tbl[2].sc = mk(-200, 9, -1, -1, 0);    tbl[2].cls = 4'd9; tbl[2].scr = -9'sd1;
        tbl[3].sc = mk(0, -1, 0, -1, 0);       tbl[3].cls = 4'd0; tbl[3].scr = 9'sd0;
        tbl[4].sc = mk(-256, 0, 255, -1, 0);   tbl[4].cls = 4'd0; tbl[4].scr = 9'sd255;
        tbl[5].sc = mk(-256, 9, 255, 4, 255);  tbl[5].cls = 4'd4; tbl[5].scr = 9'sd255;
        for (int t = 6; t < NTBL; t++) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                tbl[t].sc[i] = (t < 9) ? W'(int'($urandom_range(0, 511)) - 256)
                                       : W'(int'($urandom_range(0, 4)) - 2);
            ref_argmax(tbl[t].sc, cls, scr);
            tbl[t].cls = 4'(cls);
            tbl[t].scr = W'(scr);
        end

        reset_n = 1'b0;
        repeat (3) tick;
        check_reset_state("reset_initial");
        reset_n = 1'b1;
        tick;
        check_reset_state("after_reset_release");
        clear_model();

        // Ramp image with pix_valid held high, basic -5/100 scores.
        run_image(tbl[0].sc, int'(tbl[0].cls), int'($signed(tbl[0].scr)), 1'b0, 1'b0, 0, 1'b1);

        for (int t = 0; t < NTBL; t++) begin
            run_image(tbl[t].sc, int'(tbl[t].cls), int'($signed(tbl[t].scr)),
                      (t % 2) == 1, t == 3 || t == 8, (t == 3 || t == 8) ? 20 : 0, 1'b0);
        end

        // Reset part-way through a load discards the partial image.
        for (int k = 0; k < 300; k++) send_pixel(int'($urandom_range(1, 255)), 1'b0);
        pix_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("mid_load_reset");
        tick;
        reset_n = 1'b1;
        tick;
        clear_model();
        check_reset_state("after_mid_load_reset");
        for (int i = 0; i < NUM_CLASSES; i++)
            tbl[0].sc[i] = W'(int'($urandom_range(0, 511)) - 256);
        ref_argmax(tbl[0].sc, cls, scr);
        run_image(tbl[0].sc, cls, scr, 1'b1, 1'b0, 0, 1'b0);
        check("first_pixel_after_reset_at_00", fr(0, 0), exp_frame[0][0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lenet_host_if.md
# lenet_host_if

Host-side front/back end for `Lenet_accelerator`. It accepts a 28x28 image as a serial pixel stream over a valid/ready handshake and holds it as the accelerator's parallel `image` input. After the accelerator's fixed pipeline latency it samples the 10-entry `output_vector`, finds the winning class with a sequential argmax, and returns class and score over a second valid/ready handshake.

## Interface
Parameters:
- `BITWIDTH`, 9: signed pixel and score width; matches the accelerator's `top_bitwidth`.
- `ACC_LATENCY`, 4: clock edges from the `image` change to a valid `output_vector`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  pixel stream valid.
- `pix_ready`  out  1  pixel stream ready.
- `pix_data`  in  BITWIDTH signed  pixel, raster order (row 0 col 0 first, column fastest).
- `frame`  out  [27:0][27:0] x BITWIDTH signed  registered image; drives accelerator `image`.
- `scores`  in  [9:0] x BITWIDTH signed  from accelerator `output_vector`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accepted.
- `res_class`  out  4  winning index, 0..9.
- `res_score`  out  BITWIDTH signed  winning score.
- `busy`  out  1  high whenever state != LOAD.

## Operation
- States: LOAD, WAIT, SCAN, DONE. Reset enters LOAD.
- LOAD:
  - `pix_ready`=1.
  - Each handshake (`pix_valid & pix_ready`) writes `frame[row][col]` and advances col; col wraps 27->0 and increments row.
  - The handshake at index 783 (row 27, col 27) moves to WAIT and clears row/col and the wait counter.
- WAIT:
  - `pix_ready`=0. `frame` is frozen. The wait counter increments each cycle.
  - After ACC_LATENCY+1 cycles in WAIT, on that edge: capture all `scores` into an internal register, set best=score[0], best_idx=0, scan_idx=1, and go to SCAN.
- SCAN, one entry per cycle:
  - If `captured[scan_idx] > best` (signed compare), replace best and best_idx.
  - Ties keep the lower index.
  - After scan_idx=9 is compared, load `res_class`/`res_score` and go to DONE.
- DONE:
  - `res_valid`=1. `res_class`/`res_score` are stable until the handshake.
  - The `res_valid & res_ready` handshake returns to LOAD.
- `pix_valid` outside LOAD is ignored; no write occurs. `res_ready` outside DONE is ignored.
- Reset at any time, including mid-load or mid-scan:
  - state LOAD; row, col and counters 0.
  - `frame` all zeros.
  - `res_valid`=0, `res_class`=0, `res_score`=0.
  - A partial image is discarded.

## Timing
- Reset values: `pix_ready`=1, `res_valid`=0, `res_class`=0, `res_score`=0, `busy`=0, `frame`=0.
- `pix_ready`, `res_valid` and `busy` are decoded from registered state only; no combinational path from inputs.
- Last pixel accepted at edge E0:
  - `frame` is complete after E0.
  - `scores` are sampled at E0+ACC_LATENCY+1 (E5 by default).
  - `res_valid` rises after E0+ACC_LATENCY+10 (E14 by default).
- Full throughput: 784 cycles load + (ACC_LATENCY+10) + at least 1 DONE cycle per image.
- The DONE handshake at edge Ed gives `res_valid`=0 and `pix_ready`=1 after Ed. A pixel accepted at Ed+1 lands at (0,0).
- Until overwritten, `frame` keeps the previous image's pixels.

## Structure
- Shared package `lenet_pkg`:
  - `BITWIDTH`=9, `IMG_DIM`=28, `NUM_PIX`=784, `NUM_CLASSES`=10.
  - State enum `host_state_t`.
  - Pixel and score typedefs (signed BITWIDTH).
- One sub-module, `argmax_scan`:
  - Inputs: start pulse with the captured vector.
  - Outputs: done pulse with class and score.
  - Holds scan_idx, best and best_idx.
- The top level holds the FSM, row/col counters, wait counter and `frame` register.

## Test plan
- Reset: assert `reset_n`=0 mid-stream. Required: `pix_ready`=1, `res_valid`=0, `res_class`=0, `res_score`=0, `busy`=0, every `frame` entry 0.
- Ramp load: pixel k = (k mod 512)-256 with `pix_valid` held high. Required: `frame[r][c]` = ((28r+c) mod 512)-256, and `busy` rises after the 784th handshake.
- Basic result: `scores` = -5 everywhere except index 7 = 100. Required: `res_valid` exactly 14 cycles after the last pixel, `res_class`=7, `res_score`=100.
- Ties and signedness:
  - `scores[2]` = `scores[8]` = 50, rest 0. Required: class 2.
  - All -200 except index 9 = -1. Required: class 9, score -1.
- Backpressure: random `pix_valid` gaps, `pix_valid` held high through WAIT/SCAN, `res_ready` low for 20 cycles. Required: no extra frame writes, result stable while held, return to LOAD one cycle after the handshake.
- Mid-load reset: reset after 300 pixels, then load a full new frame. Required: first pixel lands at (0,0) and the result matches the new frame's scores.
